// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: sequencer for polynomial addition C[k] = (A[k] + B[k]) mod q.
// It reads coefficient pairs from a dual-read memory, streams them into an
// external two-stage mod_add pipeline, and writes the results back in issue
// order with tracked addresses.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start_i, hold_i     job start (accepted only in IDLE), read-issue pause
//   busy_o, done_o      job in progress, one-cycle completion pulse
//   rd_en_o, rd_addr_o  coefficient read request (same address for A and B)
//   rd_data_a/b_i       coefficient read data, MEM_LAT cycles after rd_en_o
//   add_op1/2_o         operands to mod_add (pass-through of read data)
//   add_valid_o         operand valid to mod_add (rd_en_o delayed MEM_LAT)
//   add_result_i/valid  result stream from mod_add
//   wr_en/addr/data_o   registered result write port
//
// state | meaning
// IDLE  | waiting for start_i; mod_add results are ignored
// RUN   | issuing one read per non-held cycle, addresses 0..N_COEFF-1
// DRAIN | all reads issued; waiting for the remaining results to be written
// DONE  | done_o high for one cycle, then back to IDLE
module poly_add_ctrl #(
    parameter int N_COEFF = 256,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int ADD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [11:0]       rd_data_a_i,
    input  logic [11:0]       rd_data_b_i,
    output logic [11:0]       add_op1_o,
    output logic [11:0]       add_op2_o,
    output logic              add_valid_o,
    input  logic [11:0]       add_result_i,
    input  logic              add_valid_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [11:0]       wr_data_o
);

    // One extra bit so that N_COEFF itself is representable.
    localparam int CNT_W = ADDR_W + 1;
    // Wide enough for every transaction that can sit between a read and its write.
    localparam int IF_W  = $clog2(MEM_LAT + ADD_LAT + 2) + 1;

    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(N_COEFF - 1);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N_COEFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [IF_W-1:0]    infl_cnt;
    logic [MEM_LAT-1:0] rd_vld_dly;
    logic               accept;

    assign add_op1_o   = rd_data_a_i;
    assign add_op2_o   = rd_data_b_i;
    assign add_valid_o = rd_vld_dly[MEM_LAT-1];

    // Results are only taken while a job is active, so stale pipeline
    // contents left over from an abandoned job never reach memory.
    assign accept = add_valid_i && ((state == RUN) || (state == DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            infl_cnt   <= '0;
            rd_vld_dly <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rd_en_o    <= 1'b0;
            rd_addr_o  <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
        end else begin
            rd_en_o <= 1'b0;
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;

            rd_vld_dly[0] <= rd_en_o;
            for (int i = 1; i < MEM_LAT; i++) begin
                rd_vld_dly[i] <= rd_vld_dly[i-1];
            end

            if (accept) begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= wr_cnt[ADDR_W-1:0];
                wr_data_o <= add_result_i;
                wr_cnt    <= wr_cnt + CNT_W'(1);
            end

            // Simultaneous issue and retire leaves the count unchanged.
            if (rd_en_o && !accept) begin
                infl_cnt <= infl_cnt + IF_W'(1);
            end else if (!rd_en_o && accept) begin
                infl_cnt <= infl_cnt - IF_W'(1);
            end

            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i) begin
                        state    <= RUN;
                        rd_cnt   <= '0;
                        wr_cnt   <= '0;
                        infl_cnt <= '0;
                    end
                end
                RUN: begin
                    busy_o <= 1'b1;
                    if (!hold_i) begin
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= rd_cnt[ADDR_W-1:0];
                        rd_cnt    <= rd_cnt + CNT_W'(1);
                        if (rd_cnt == LAST_RD) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((wr_cnt == N_CNT) && (infl_cnt == '0)) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        busy_o <= 1'b1;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_add_ctrl.sv
module tb_poly_add_ctrl;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int Q  = 3329;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          hold_i = 1'b0;
    logic          busy_o, done_o, rd_en_o, add_valid_o, wr_en_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [11:0]   rd_data_a_i, rd_data_b_i, add_op1_o, add_op2_o;
    logic [11:0]   add_result_i, wr_data_o;
    logic          add_valid_i;
    logic          inject = 1'b0;

    poly_add_ctrl #(.N_COEFF(N), .ADDR_W(AW), .MEM_LAT(1), .ADD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_i(hold_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
        .add_op1_o(add_op1_o), .add_op2_o(add_op2_o), .add_valid_o(add_valid_o),
        .add_result_i(add_result_i), .add_valid_i(add_valid_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    always #5 clk = ~clk;

    // Environment: one-cycle coefficient memory and a two-stage mod_add.
    logic [11:0] mem_a [N];
    logic [11:0] mem_b [N];
    logic [11:0] rd_a = '0, rd_b = '0;
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [12:0] s1_sum = '0;
    logic [11:0] s2_r = '0;

    always @(posedge clk) begin
        if (rd_en_o) begin
            rd_a <= mem_a[rd_addr_o];
            rd_b <= mem_b[rd_addr_o];
        end
        s1_v   <= add_valid_o;
        s1_sum <= {1'b0, add_op1_o} + {1'b0, add_op2_o};
        s2_v   <= s1_v;
        s2_r   <= (s1_sum >= 13'(Q)) ? 12'(s1_sum - 13'(Q)) : s1_sum[11:0];
    end

    assign rd_data_a_i  = rd_a;
    assign rd_data_b_i  = rd_b;
    assign add_result_i = s2_r;
    assign add_valid_i  = s2_v | inject;

    int n_chk = 0;
    int n_fail = 0;

    // Observations of one job, relative to the start edge T.
    int          o_first_wr, o_done_rel, o_done_cnt, o_wr_cnt, o_addr_err, o_data_err;
    int          o_rd_cnt, o_rd_seq_err, o_rd_low, o_span;
    logic        o_busy [0:400];
    logic [11:0] o_wr_data [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_c(input int k);
        return (int'(mem_a[k]) + int'(mem_b[k])) % Q;
    endfunction

    // Reference timing: one read per non-held cycle starting at T+1,
    // each result written 4 cycles after its read, done the cycle after.
    function automatic int model_done(input int hf, input int ht);
        int reads = 0;
        int rel = 0;
        while (reads < N) begin
            rel++;
            if (!(rel >= hf && rel <= ht)) reads++;
        end
        return rel + 5;
    endfunction

    function automatic int busy_errs(input int exp_done);
        int e = 0;
        for (int r = 0; r <= o_span; r++) begin
            if (o_busy[r] !== ((r >= 1) && (r < exp_done))) e++;
        end
        return e;
    endfunction

    task automatic fill(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: begin mem_a[k] = 12'(k);    mem_b[k] = 12'd3328; end
                1: begin mem_a[k] = 12'd3328;  mem_b[k] = 12'd3328; end
                2: begin mem_a[k] = 12'd0;     mem_b[k] = 12'd0;    end
                default: begin
                    mem_a[k] = 12'($urandom_range(0, Q - 1));
                    mem_b[k] = 12'($urandom_range(0, Q - 1));
                end
            endcase
        end
    endtask

    task automatic run_job(input int hf, input int ht, input int start2_at);
        int rel;
        o_first_wr = -1; o_done_rel = -1; o_done_cnt = 0; o_wr_cnt = 0;
        o_addr_err = 0; o_data_err = 0; o_rd_cnt = 0; o_rd_seq_err = 0; o_rd_low = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        o_busy[0] = busy_o;
        o_span = 0;
        for (rel = 1; rel <= 400; rel++) begin
            hold_i  = (rel >= hf && rel <= ht);
            start_i = (rel == start2_at);
            tick();
            start_i = 1'b0;
            o_busy[rel] = busy_o;
            o_span = rel;
            if (rd_en_o) begin
                if (rd_addr_o != AW'(o_rd_cnt)) o_rd_seq_err++;
                o_rd_cnt++;
            end else if (o_rd_cnt > 0 && o_rd_cnt < N) begin
                o_rd_low++;
            end
            if (wr_en_o) begin
                if (o_first_wr < 0) o_first_wr = rel;
                if (wr_addr_o != AW'(o_wr_cnt)) o_addr_err++;
                if (o_wr_cnt < N) begin
                    o_wr_data[o_wr_cnt] = wr_data_o;
                    if (wr_data_o != 12'(exp_c(o_wr_cnt))) o_data_err++;
                end
                o_wr_cnt++;
            end
            if (done_o) begin
                o_done_cnt++;
                if (o_done_rel < 0) o_done_rel = rel;
            end
            if (o_done_rel >= 0 && rel >= o_done_rel + 3) break;
        end
        hold_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_chk++;
        if ({busy_o, done_o, rd_en_o, wr_en_o, add_valid_o, rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b wr_en=%b add_valid=%b rd_addr=%0d wr_addr=%0d wr_data=%0d expected all 0",
                     busy_o, done_o, rd_en_o, wr_en_o, add_valid_o, rd_addr_o, wr_addr_o, wr_data_o);
        end
        rst_n = 1'b1;
        tick(); tick();
        n_chk++;
        if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b wr_en=%b expected 0 0", busy_o, wr_en_o);
        end
    endtask

    task automatic test_basic();
        fill(0);
        run_job(-1, -1, -1);
        n_chk++;
        if (o_first_wr != 5) begin n_fail++; $display("FAIL basic_first_wr: got T+%0d expected T+5", o_first_wr); end
        n_chk++;
        if (o_done_rel != 261) begin n_fail++; $display("FAIL basic_done_time: got T+%0d expected T+261", o_done_rel); end
        n_chk++;
        if (o_done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", o_done_cnt); end
        n_chk++;
        if (o_wr_cnt != N || o_addr_err != 0) begin
            n_fail++; $display("FAIL basic_writes: got %0d writes %0d addr errors expected %0d and 0", o_wr_cnt, o_addr_err, N);
        end
        n_chk++;
        if (o_wr_data[0] != 12'd3328 || o_wr_data[1] != 12'd0 || o_wr_data[200] != 12'd199) begin
            n_fail++; $display("FAIL basic_values: got C0=%0d C1=%0d C200=%0d expected 3328 0 199",
                               o_wr_data[0], o_wr_data[1], o_wr_data[200]);
        end
        n_chk++;
        if (o_data_err != 0) begin n_fail++; $display("FAIL basic_data: got %0d wrong results expected 0", o_data_err); end
        n_chk++;
        if (busy_errs(261) != 0) begin n_fail++; $display("FAIL basic_busy: got %0d busy mismatches expected 0", busy_errs(261)); end
        n_chk++;
        if (o_rd_cnt != N || o_rd_seq_err != 0) begin
            n_fail++; $display("FAIL basic_reads: got %0d reads %0d order errors expected %0d and 0", o_rd_cnt, o_rd_seq_err, N);
        end
    endtask

    task automatic test_boundary();
        fill(1);
        run_job(-1, -1, -1);
        n_chk++;
        if (o_data_err != 0 || o_wr_data[0] != 12'd3327 || o_wr_data[N-1] != 12'd3327) begin
            n_fail++; $display("FAIL max_values: got %0d errors C0=%0d C255=%0d expected 0 3327 3327",
                               o_data_err, o_wr_data[0], o_wr_data[N-1]);
        end
        n_chk++;
        if (o_addr_err != 0 || o_wr_cnt != N) begin
            n_fail++; $display("FAIL max_addr_seq: got %0d addr errors %0d writes expected 0 %0d", o_addr_err, o_wr_cnt, N);
        end
        fill(2);
        run_job(-1, -1, -1);
        n_chk++;
        if (o_data_err != 0 || o_wr_data[17] != 12'd0) begin
            n_fail++; $display("FAIL zero_values: got %0d errors C17=%0d expected 0 0", o_data_err, o_wr_data[17]);
        end
    endtask

    task automatic test_hold();
        fill(3);
        run_job(10, 19, -1);
        n_chk++;
        if (o_rd_low != 10) begin n_fail++; $display("FAIL hold_low_cycles: got %0d expected 10", o_rd_low); end
        n_chk++;
        if (o_done_rel != 271) begin n_fail++; $display("FAIL hold_done_time: got T+%0d expected T+271", o_done_rel); end
        n_chk++;
        if (o_rd_cnt != N || o_rd_seq_err != 0) begin
            n_fail++; $display("FAIL hold_reads: got %0d reads %0d order errors expected %0d and 0", o_rd_cnt, o_rd_seq_err, N);
        end
        n_chk++;
        if (o_wr_cnt != N || o_data_err != 0 || o_addr_err != 0) begin
            n_fail++; $display("FAIL hold_writes: got %0d writes %0d data %0d addr errors expected %0d 0 0",
                               o_wr_cnt, o_data_err, o_addr_err, N);
        end
        n_chk++;
        if (busy_errs(271) != 0) begin n_fail++; $display("FAIL hold_busy: got %0d mismatches expected 0", busy_errs(271)); end
    endtask

    task automatic test_start_while_busy();
        fill(3);
        run_job(-1, -1, 50);
        n_chk++;
        if (o_done_cnt != 1 || o_wr_cnt != N) begin
            n_fail++; $display("FAIL restart_ignored: got %0d done %0d writes expected 1 %0d", o_done_cnt, o_wr_cnt, N);
        end
        n_chk++;
        if (o_done_rel != 261) begin n_fail++; $display("FAIL restart_done_time: got T+%0d expected T+261", o_done_rel); end
        fill(3);
        run_job(-1, -1, -1);
        n_chk++;
        if (o_done_rel != 261 || o_data_err != 0 || o_wr_cnt != N) begin
            n_fail++; $display("FAIL second_job: got done T+%0d %0d errors %0d writes expected T+261 0 %0d",
                               o_done_rel, o_data_err, o_wr_cnt, N);
        end
    endtask

    task automatic test_reset_mid_job();
        int seen_done = 0;
        int seen_wr = 0;
        fill(3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int r = 1; r < 100; r++) begin
            tick();
            if (done_o) seen_done++;
        end
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset: got %b expected 1", busy_o); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy_o, done_o, rd_en_o, wr_en_o, add_valid_o, rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got busy=%b done=%b rd_en=%b wr_en=%b add_valid=%b rd_addr=%0d wr_addr=%0d wr_data=%0d expected all 0",
                     busy_o, done_o, rd_en_o, wr_en_o, add_valid_o, rd_addr_o, wr_addr_o, wr_data_o);
        end
        tick(); tick();
        rst_n = 1'b1;
        inject = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            if (wr_en_o) seen_wr++;
            if (done_o) seen_done++;
        end
        inject = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            if (wr_en_o) seen_wr++;
            if (done_o) seen_done++;
        end
        n_chk++;
        if (seen_wr != 0) begin n_fail++; $display("FAIL stale_result_written: got %0d writes expected 0", seen_wr); end
        n_chk++;
        if (seen_done != 0) begin n_fail++; $display("FAIL done_after_abort: got %0d pulses expected 0", seen_done); end
        run_job(-1, -1, -1);
        n_chk++;
        if (o_done_rel != 261 || o_data_err != 0 || o_wr_cnt != N || o_addr_err != 0) begin
            n_fail++; $display("FAIL job_after_reset: got done T+%0d %0d data %0d addr errors %0d writes expected T+261 0 0 %0d",
                               o_done_rel, o_data_err, o_addr_err, o_wr_cnt, N);
        end
    endtask

    task automatic test_drain_hold();
        fill(3);
        run_job(257, 300, -1);
        n_chk++;
        if (o_done_rel != 261 || o_done_cnt != 1) begin
            n_fail++; $display("FAIL drain_hold_done: got T+%0d count %0d expected T+261 count 1", o_done_rel, o_done_cnt);
        end
        n_chk++;
        if (o_wr_cnt != N || o_data_err != 0) begin
            n_fail++; $display("FAIL drain_hold_writes: got %0d writes %0d errors expected %0d 0", o_wr_cnt, o_data_err, N);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int hf, ht, ed;
            hf = $urandom_range(1, 240);
            ht = hf + $urandom_range(0, 30) - 1;
            ed = model_done(hf, ht);
            fill(3);
            run_job(hf, ht, -1);
            n_chk++;
            if (o_done_rel != ed) begin
                n_fail++; $display("FAIL rand_done_time: hold %0d..%0d got T+%0d expected T+%0d", hf, ht, o_done_rel, ed);
            end
            n_chk++;
            if (o_wr_cnt != N || o_data_err != 0 || o_addr_err != 0 || o_done_cnt != 1) begin
                n_fail++; $display("FAIL rand_writes: got %0d writes %0d data %0d addr errors %0d done expected %0d 0 0 1",
                                   o_wr_cnt, o_data_err, o_addr_err, o_done_cnt, N);
            end
            n_chk++;
            if (busy_errs(ed) != 0) begin n_fail++; $display("FAIL rand_busy: got %0d mismatches expected 0", busy_errs(ed)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_start_while_busy();
        test_reset_mid_job();
        test_drain_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_add_ctrl.md
Name: poly_add_ctrl

Overview:
- Sequencer that drives one two-stage mod_add pipeline to compute a full polynomial sum C[k] = (A[k] + B[k]) mod 3329 for k = 0..N_COEFF-1.
- Issues reads of coefficient pairs from a dual-read coefficient memory, streams them into mod_add and writes the results back with tracked addresses.
- Raises done_o when the last result has been written.
- Sits between the poly-arith memory subsystem and the mod_add datapath.

Parameters:
- N_COEFF, 256, coefficients per polynomial.
- ADDR_W, 8, coefficient address width; must satisfy 2^ADDR_W >= N_COEFF.
- MEM_LAT, 1, cycles from rd_en_o to valid rd_data_*_i.
- ADD_LAT, 2, mod_add latency from valid_i to valid_o.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- hold_i  in  1  pause issue of new reads; in-flight work completes
- busy_o  out  1  high from the cycle after accepted start through the last write
- done_o  out  1  one-cycle pulse after the final write
- rd_en_o  out  1  memory read enable
- rd_addr_o  out  ADDR_W  read address (same for A and B banks)
- rd_data_a_i  in  12  coefficient A[k], coeff_t
- rd_data_b_i  in  12  coefficient B[k], coeff_t
- add_op1_o  out  12  to mod_add op1_i (combinational from rd_data_a_i)
- add_op2_o  out  12  to mod_add op2_i (combinational from rd_data_b_i)
- add_valid_o  out  1  to mod_add valid_i: rd_en_o delayed MEM_LAT cycles
- add_result_i  in  12  from mod_add result_o
- add_valid_i  in  1  from mod_add valid_o
- wr_en_o  out  1  result write enable, registered
- wr_addr_o  out  ADDR_W  result address, registered
- wr_data_o  out  12  result value, registered copy of add_result_i

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; read counter, write counter and in-flight counter cleared; MEM_LAT delay line cleared.
  - busy_o, done_o, rd_en_o, wr_en_o and add_valid_o are 0.
  - rd_addr_o, wr_addr_o and wr_data_o are 0.
  - Reset mid-operation abandons the job. No partial completion is signalled.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 at edge T moves to RUN; busy_o=1 from T+1.
  - add_valid_i is ignored in IDLE (stale pipeline contents are not written).
- RUN:
  - Each cycle with hold_i=0: rd_en_o=1, rd_addr_o=read counter, read counter +1.
  - hold_i=1: rd_en_o=0 and the counter is held.
  - After issuing address N_COEFF-1, move to DRAIN. There are no further reads.
- DRAIN:
  - Wait until the write counter equals N_COEFF.
  - hold_i has no effect in DRAIN.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then IDLE.
  - A start_i asserted in the DONE cycle is ignored; start is accepted again from IDLE.
- Datapath timing:
  - add_valid_o = rd_en_o delayed MEM_LAT cycles.
  - Each add_valid_i=1 registers wr_en_o=1, wr_addr_o=write counter and wr_data_o=add_result_i at the next edge, then increments the write counter.
  - Result address order equals issue order because mod_add is in-order and fixed-latency.
  - Read-to-write latency = MEM_LAT + ADD_LAT + 1 = 4 cycles.
- No-hold timing, start at edge T:
  - Reads at cycles T+1..T+256.
  - Writes of address k at cycle T+5+k.
  - Last write at T+260; done_o at T+261.
- In-flight counter:
  - Increments on rd_en_o, decrements on add_valid_i; a simultaneous increment and decrement leaves it unchanged.
  - Never exceeds MEM_LAT + ADD_LAT.
  - Used for the DRAIN exit check together with the write counter.
- Counters are ADDR_W+1 bits wide, so N_COEFF=256 is representable without wrap. rd_addr_o and wr_addr_o are the low ADDR_W bits.
- start_i while busy_o=1 is ignored; it does not queue or restart.
- The controller performs no arithmetic on coefficients; mod-Q reduction is entirely in mod_add.

Test Plan:
- Basic add: A[k]=k, B[k]=3328, start pulse at T -> writes C[0]=3328, C[1]=0, C[k]=k-1 for k>=1; first wr_en_o at T+5; done_o single pulse at T+261; busy_o low at T+261.
- Boundary values: A[k]=3328, B[k]=3328 for all k -> every wr_data_o=3327. A=B=0 -> all 0. wr_addr_o sequence is 0..255 with no gaps.
- Hold: hold_i=1 for cycles T+10..T+19 -> rd_en_o low exactly 10 cycles; no address skipped or repeated; done_o at T+271; all 256 writes correct.
- Start while busy: second start_i pulse at T+50 -> ignored; exactly 256 writes and one done_o. A new start after done_o runs a second full job.
- Reset mid-job: rst_n low at T+100 for 2 cycles -> all outputs 0 immediately; no done_o. Residual add_valid_i after reset is not written. A fresh start completes normally.
- Hold in DRAIN: hold_i=1 from T+257 to T+300 -> DRAIN completes regardless; done_o at T+261.
